reset_seq_gen: RTL

Parametrised multi-domain reset sequencer; the successor of the single-output reset generator.
- Filters the external board reset pin and accepts software reset requests.
- Stretches every reset to a minimum hold time, then releases CH reset domains in ascending order with a fixed gap between them.
- Sits at the top level between the pad/CPU register block and all clocked subsystems on sys_clk.

---
 rtl/reset_seq_gen_if.sv | 23 ++
 rtl/reset_seq_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/reset_seq_gen_if.sv
// Request and reset-output bundle between the pad/CPU register block and the
// reset sequencer.
interface reset_seq_gen_if #(
  parameter int unsigned CH = 4
);
  logic          p_rst_n;
  logic          sw_rst_req;
  logic [CH-1:0] ch_mask;
  logic [CH-1:0] sys_rst_n;
  logic          rst_busy;
  logic          release_done;
  logic [1:0]    rst_cause;

  modport master (
    output p_rst_n, sw_rst_req, ch_mask,
    input  sys_rst_n, rst_busy, release_done, rst_cause
  );

  modport slave (
    input  p_rst_n, sw_rst_req, ch_mask,
    output sys_rst_n, rst_busy, release_done, rst_cause
  );
endinterface

// File: rtl/reset_seq_gen.sv
// Multi-domain reset sequencer: filters the board reset pin, merges software
// requests, holds the targeted domains in reset, then releases them in order.
module reset_seq_gen #(
  parameter int unsigned CH   = 4,
  parameter int unsigned FILT = 4,
  parameter int unsigned HOLD = 16,
  parameter int unsigned GAP  = 8
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  reset_seq_gen_if.slave rif
);

  localparam int unsigned M1   = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned MAXC = (M1 > FILT) ? M1 : FILT;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam int unsigned KW   = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [1:0] {
    S_HOLD,
    S_STAGE,
    S_RUN
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [KW-1:0]  k_q, k_d;
  logic [CH-1:0]  tgt_q, tgt_d;
  logic [CH-1:0]  rstn_q, rstn_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [1:0]     cause_q, cause_d;
  logic           s1_q, s2_q;
  logic [CW-1:0]  fcnt_q, fcnt_d;

  logic           pin_req;
  logic           pin_act;
  logic           sw_req;
  logic [CH-1:0]  new_set;

  // Pin fires once on the edge the filter count saturates; pin_act then
  // keeps the hold counter pinned at zero until the synced pin goes high.
  always_comb begin
    pin_req = !s2_q && (fcnt_q == CW'(FILT - 1));
    pin_act = !s2_q && (fcnt_q == CW'(FILT));
    sw_req  = rif.sw_rst_req && (|rif.ch_mask);
    new_set = pin_req ? {CH{1'b1}} : rif.ch_mask;
    if (s2_q) begin
      fcnt_d = '0;
    end else if (pin_act) begin
      fcnt_d = fcnt_q;
    end else begin
      fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    tgt_d   = tgt_q;
    rstn_d  = rstn_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cause_d = cause_q;

    if (pin_req || sw_req) begin
      tgt_d   = tgt_q | new_set;
      rstn_d  = rstn_q & ~(tgt_q | new_set);
      state_d = S_HOLD;
      cnt_d   = '0;
      k_d     = '0;
      busy_d  = 1'b1;
      // Cause is latched fresh from idle; mid-sequence only the pin can overwrite it.
      if (state_q == S_RUN) begin
        cause_d = pin_req ? 2'b01 : 2'b10;
      end else if (pin_req) begin
        cause_d = 2'b01;
      end
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (pin_act) begin
            cnt_d = '0;
          end else if (cnt_q == CW'(HOLD - 1)) begin
            rstn_d[0] = 1'b1;
            cnt_d     = '0;
            if (CH == 1) begin
              state_d = S_RUN;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              tgt_d   = '0;
            end else begin
              state_d = S_STAGE;
              k_d     = KW'(1);
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_STAGE: begin
          if (cnt_q == CW'(GAP - 1)) begin
            rstn_d[k_q] = 1'b1;
            cnt_d       = '0;
            if (k_q == KW'(CH - 1)) begin
              state_d = S_RUN;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              tgt_d   = '0;
            end else begin
              k_d = k_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
        end
        default: begin
          state_d = S_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      k_q     <= '0;
      tgt_q   <= '1;
      rstn_q  <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      cause_q <= 2'b00;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      tgt_q   <= tgt_d;
      rstn_q  <= rstn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cause_q <= cause_d;
      s1_q    <= rif.p_rst_n;
      s2_q    <= s1_q;
      fcnt_q  <= fcnt_d;
    end
  end

  assign rif.sys_rst_n    = rstn_q;
  assign rif.rst_busy     = busy_q;
  assign rif.release_done = done_q;
  assign rif.rst_cause    = cause_q;

endmodule
